// File: rtl/atari_bus_pkg.sv
// Shared Atari bus definitions: POKEY window base, the bus synchroniser
// depth, the FIFO entry type and the capture register layout.
package atari_bus_pkg;

    localparam logic [11:0] POKEY_BASE      = 12'h045;
    localparam int          BUS_SYNC_STAGES = 2;

    // One POKEY register write handed to the core.
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } pokey_wr_t;

    // Bus state sampled while PHI2 is high.
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic        halt;
    } bus_capture_t;

    // True when the address falls inside the 16-byte window at base*16.
    function automatic logic addr_in_window(input logic [15:0] addr,
                                            input logic [11:0] base);
        return (addr[15:4] == base);
    endfunction

endpackage

// File: rtl/pokey_wr_fifo.sv
// Synchronous FIFO of POKEY register writes. Push is refused only when full
// with no simultaneous pop; deciding what to do about a refused push is the
// parent's job.
module pokey_wr_fifo
    import atari_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  pokey_wr_t   push_data_i,
    input  logic        pop_i,
    output pokey_wr_t   head_o,
    output logic [AW:0] level_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEVEL_ZERO = {(AW+1){1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};

    pokey_wr_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push_s, do_pop_s;

    // Qualify push/pop against occupancy and derive next pointers and level
    always_comb begin
        do_pop_s  = pop_i && !empty_q;
        do_push_s = push_i && (!full_q || do_pop_s);

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (do_push_s && !do_pop_s) begin
            level_d = level_q + LEVEL_ONE;
        end else if (do_pop_s && !do_push_s) begin
            level_d = level_q - LEVEL_ONE;
        end else begin
            level_d = level_q;
        end

        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == LEVEL_ZERO);
    end

    // Pointer, level and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            level_q  <= LEVEL_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= pokey_wr_t'(12'h000);
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/pokey_write_capture.sv
// Captures CPU writes to the POKEY register window on the falling edge of a
// glitch-filtered PHI2 and queues them for the POKEY core.
// Build option: define POKEY_CAPTURE_FILTER_EN to enable the PHI2 run-length
// filter (FILTER samples); without it filtered PHI2 is the synchronised PHI2.
module pokey_write_capture
    import atari_bus_pkg::*;
#(
    parameter logic [11:0] ADDR_BASE  = POKEY_BASE,
    parameter int          FIFO_DEPTH = 4,
    parameter int          FILTER     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 a,
    input  logic [7:0]                  d_in,
    input  logic                        phi2,
    input  logic                        rw,
    input  logic                        halt,
    output logic                        wr_valid,
    output logic [3:0]                  wr_addr,
    output logic [7:0]                  wr_data,
    input  logic                        wr_ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int BUS_W = 27;

    logic [BUS_W-1:0] sync_q [BUS_SYNC_STAGES];
    logic [BUS_W-1:0] bus_s2;
    logic [15:0]      a_s2;
    logic [7:0]       d_s2;
    logic             phi2_s2, rw_s2, halt_s2;

    logic             phi2_f;
    logic             phi2_f_prev_q;
    bus_capture_t     cap_q, cap_d;
    logic             commit_s, pop_s;
    logic             overflow_q, overflow_d;
    logic             fifo_full_s, fifo_empty_s;
    pokey_wr_t        push_data_s, head_s;

    // Shared synchroniser chain keeps all bus inputs mutually aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUS_SYNC_STAGES; i++) begin
                sync_q[i] <= {BUS_W{1'b0}};
            end
        end else begin
            sync_q[0] <= {a, d_in, phi2, rw, halt};
            for (int i = 1; i < BUS_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_s2  = sync_q[BUS_SYNC_STAGES-1];
    assign a_s2    = bus_s2[26:11];
    assign d_s2    = bus_s2[10:3];
    assign phi2_s2 = bus_s2[2];
    assign rw_s2   = bus_s2[1];
    assign halt_s2 = bus_s2[0];

`ifdef POKEY_CAPTURE_FILTER_EN
    localparam logic [2:0] FILTER_LAST = 3'(FILTER - 1);

    logic       phi2_f_q, phi2_f_d;
    logic [2:0] filt_cnt_q, filt_cnt_d;

    // Filtered PHI2 follows the synchronised PHI2 only after a full run of mismatches
    always_comb begin
        if (phi2_s2 == phi2_f_q) begin
            phi2_f_d   = phi2_f_q;
            filt_cnt_d = 3'd0;
        end else if (filt_cnt_q == FILTER_LAST) begin
            phi2_f_d   = phi2_s2;
            filt_cnt_d = 3'd0;
        end else begin
            phi2_f_d   = phi2_f_q;
            filt_cnt_d = filt_cnt_q + 3'd1;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi2_f_q   <= 1'b0;
            filt_cnt_q <= 3'd0;
        end else begin
            phi2_f_q   <= phi2_f_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign phi2_f = phi2_f_q;
`else
    assign phi2_f = phi2_s2;
`endif

    // Delayed filtered PHI2 for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi2_f_prev_q <= 1'b0;
        end else begin
            phi2_f_prev_q <= phi2_f;
        end
    end

    // Sample the bus while PHI2 is high; hold the last sample once it drops
    always_comb begin
        if (phi2_s2) begin
            cap_d = '{a: a_s2, d: d_s2, rw: rw_s2, halt: halt_s2};
        end else begin
            cap_d = cap_q;
        end
    end

    // Capture register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= bus_capture_t'(26'h0000000);
        end else begin
            cap_q <= cap_d;
        end
    end

    // A commit is a CPU write (not DMA) inside the window, seen at PHI2 fall
    always_comb begin
        commit_s    = phi2_f_prev_q && !phi2_f && !cap_q.rw && cap_q.halt &&
                      addr_in_window(cap_q.a, ADDR_BASE);
        push_data_s = '{addr: cap_q.a[3:0], data: cap_q.d};
        pop_s       = !fifo_empty_s && wr_ready;
    end

    pokey_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (commit_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .level_o     (level),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // A commit into a full FIFO with no pop this cycle is dropped and flagged
    always_comb begin
        if (commit_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
    assign wr_valid = !fifo_empty_s;
    assign wr_addr  = head_s.addr;
    assign wr_data  = head_s.data;

endmodule

// File: tb/tb_pokey_write_capture.sv
// Scoreboard bench for pokey_write_capture: stimulus predicts beats into a
// queue, a forked monitor pops and compares every accepted beat.
module tb_pokey_write_capture;
    import atari_bus_pkg::*;

    localparam int DEPTH    = 4;
    localparam int FILTER   = 2;
    localparam int HIGH_CYC = 8;
    localparam int LOW_CYC  = 7;
`ifdef POKEY_CAPTURE_FILTER_EN
    localparam int PUSH_EDGE     = 2 + FILTER;
    localparam int GLITCH_PUSHES = 1;
`else
    localparam int PUSH_EDGE     = 2;
    localparam int GLITCH_PUSHES = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic        phi2 = 1'b0;
    logic        rw = 1'b1;
    logic        halt = 1'b1;
    logic        wr_ready = 1'b0;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        overflow;
    logic [2:0]  level;

    pokey_wr_t sb[$];
    bit        exp_ovf;
    int        n_checks = 0;
    int        n_fail = 0;
    int        valid_cycles = 0;
    int        pops_seen = 0;

    pokey_write_capture #(
        .ADDR_BASE  (12'h045),
        .FIFO_DEPTH (DEPTH),
        .FILTER     (FILTER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .d_in     (d_in),
        .phi2     (phi2),
        .rw       (rw),
        .halt     (halt),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Pops the expected queue whenever the DUT hands over a beat.
    task automatic monitor_loop();
        pokey_wr_t exp;
        forever begin
            @(negedge clk);
            if (!rst && wr_valid) begin
                valid_cycles++;
                if (wr_ready) begin
                    pops_seen++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL beat_unexpected: got addr=%0h data=%0h, expected no beat",
                                 wr_addr, wr_data);
                    end else begin
                        exp = sb.pop_front();
                        check("beat_addr", 32'(wr_addr), 32'(exp.addr));
                        check("beat_data", 32'(wr_data), 32'(exp.data));
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        phi2 = 1'b0;
        rw = 1'b1;
        halt = 1'b1;
        wr_ready = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One full PHI2 cycle (high then low). Expected beats are predicted from
    // the bus cycle's meaning; lat reports the low-phase edge index at which
    // wr_valid rose (-1 if it did not).
    task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] data,
                             input logic rw_v, input logic halt_v, input bit glitch,
                             input bit ready_at_push, output int lat);
        int   n;
        logic was_valid;
        n = (!rw_v && halt_v && ((addr / 16) == 16'h0045)) ? (glitch ? GLITCH_PUSHES : 1) : 0;
        for (int i = 0; i < n; i++) begin
            if (sb.size() < DEPTH || ready_at_push)
                sb.push_back('{addr: 4'(addr % 16), data: data});
            else
                exp_ovf = 1'b1;
        end
        a = addr;
        d_in = data;
        rw = rw_v;
        halt = halt_v;
        for (int k = 0; k < HIGH_CYC; k++) begin
            phi2 = (glitch && k == 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        phi2 = 1'b0;
        lat = -1;
        was_valid = wr_valid;
        for (int k = 0; k < LOW_CYC; k++) begin
            if (ready_at_push) wr_ready = (k == PUSH_EDGE);
            @(posedge clk);
            #1;
            if (lat < 0 && !was_valid && wr_valid) lat = k;
        end
        if (ready_at_push) wr_ready = 1'b0;
        rw = 1'b1;
    endtask

    task automatic drain(input string name);
        int t;
        wr_ready = 1'b1;
        t = 0;
        while ((sb.size() != 0 || wr_valid) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        check({name, "_level0"}, 32'(level), 32'd0);
    endtask

    initial begin
        int          lat;
        int          vc0;
        int          p0;
        logic [15:0] ra;
        logic        rwv, hv;

        fork
            monitor_loop();
        join_none

        do_reset();
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);

        // Single write with latency measurement
        wr_ready = 1'b1;
        p0 = pops_seen;
        bus_cycle(16'h0451, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("single_latency", 32'(lat), 32'(PUSH_EDGE));
        repeat (10) @(posedge clk);
        #1;
        check("single_beats", 32'(pops_seen - p0), 32'd1);
        check("single_sb_empty", 32'(sb.size()), 32'd0);

        // Reads, DMA cycles and out-of-window writes never push
        vc0 = valid_cycles;
        bus_cycle(16'h0452, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, lat);
        bus_cycle(16'h0453, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        bus_cycle(16'h0460, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        repeat (5) @(posedge clk);
        #1;
        check("qual_no_valid", 32'(valid_cycles - vc0), 32'd0);
        check("qual_level", 32'(level), 32'd0);

        // Randomised bus traffic with random back-pressure
        for (int i = 0; i < 24; i++) begin
            ra  = ($urandom_range(0, 3) != 0) ? (16'h0450 + 16'($urandom_range(0, 15)))
                                               : 16'($urandom);
            rwv = ($urandom_range(0, 3) == 0);
            hv  = ($urandom_range(0, 4) != 0);
            wr_ready = 1'($urandom_range(0, 1));
            bus_cycle(ra, 8'($urandom), rwv, hv, 1'b0, 1'b0, lat);
        end
        drain("random");
        check("random_overflow", 32'(overflow), 32'(exp_ovf));

        // Back-pressure until full, fifth write is dropped
        do_reset();
        for (int i = 0; i < 5; i++)
            bus_cycle(16'h0450 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_model", 32'(overflow), 32'(exp_ovf));
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Glitch inside the high phase
        wr_ready = 1'b1;
        p0 = pops_seen;
        bus_cycle(16'h0455, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, lat);
        repeat (10) @(posedge clk);
        #1;
        check("glitch_beats", 32'(pops_seen - p0), 32'(GLITCH_PUSHES));

        // Full FIFO with a pop on the push cycle
        do_reset();
        for (int i = 0; i < 4; i++)
            bus_cycle(16'h0450 + 16'(i), 8'h20 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("fullpop_pre_level", 32'(level), 32'd4);
        bus_cycle(16'h0454, 8'h24, 1'b0, 1'b1, 1'b0, 1'b1, lat);
        check("fullpop_level", 32'(level), 32'd4);
        check("fullpop_no_ovf", 32'(overflow), 32'd0);
        drain("fullpop");

        // Asynchronous reset with entries queued
        do_reset();
        for (int i = 0; i < 3; i++)
            bus_cycle(16'h0458 + 16'(i), 8'h40 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("midrst_pre_level", 32'(level), 32'd3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(wr_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        sb.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        wr_ready = 1'b1;
        bus_cycle(16'h0457, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("postrst_latency", 32'(lat), 32'(PUSH_EDGE));
        drain("postrst");

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
